// File: rtl/bcd2b_pkg.sv
// Shared types and helpers for the multi-digit BCD-to-binary sequencer.
package bcd2b_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;

    // Wide enough for 8 digits (10^8 < 2^27); callers cast to their own width.
    localparam int ACC_MAX_W = 32;

    function automatic logic [ACC_MAX_W-1:0] mul10(input logic [ACC_MAX_W-1:0] acc);
        return (acc << 3) + (acc << 1);
    endfunction

endpackage

// File: rtl/bcd2b.sv
// Single-digit BCD decoder: passes a decimal nibble through, flags anything above 9.
module bcd2b
    import bcd2b_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [3:0] bin,
    output logic       invalid
);

    always_comb begin
        invalid = (bcd > 4'(BCD_MAX_DIGIT));
        bin     = invalid ? '0 : bcd;
    end

endmodule

// File: rtl/bcd2b_ctrl.sv
// Converts a packed multi-digit BCD word to binary, one digit per clock, MSD first,
// using a single bcd2b decoder and a shift-add accumulator.
module bcd2b_ctrl
    import bcd2b_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_bin,
    output logic                          out_invalid,
    output logic                          busy
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    state_t            state, state_next;
    logic [BCD_W-1:0]  shreg;
    logic [OUT_W-1:0]  acc, acc_next;
    logic [CNT_W-1:0]  cnt;
    logic              inv, inv_next;
    logic [3:0]        dig_bin, digit;
    logic              dig_invalid;
    logic              last_digit;

    bcd2b u_digit (
        .bcd     (shreg[BCD_W-1 -: BCD_DIGIT_W]),
        .bin     (dig_bin),
        .invalid (dig_invalid)
    );

    always_comb begin
        digit      = dig_invalid ? '0 : dig_bin;
        acc_next   = OUT_W'(mul10(ACC_MAX_W'(acc))) + OUT_W'(digit);
        inv_next   = inv | dig_invalid;
        last_digit = (cnt == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CONV;
            end
            CONV: begin
                busy = 1'b1;
                if (last_digit) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            acc         <= '0;
            cnt         <= '0;
            inv         <= 1'b0;
            out_bin     <= '0;
            out_invalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_bcd;
                        acc   <= '0;
                        cnt   <= '0;
                        inv   <= 1'b0;
                    end
                end
                CONV: begin
                    acc   <= acc_next;
                    inv   <= inv_next;
                    shreg <= shreg << BCD_DIGIT_W;
                    cnt   <= cnt + 1'b1;
                    // Result is taken from the next-state values so the final digit is included.
                    if (last_digit) begin
                        out_bin     <= inv_next ? '0 : acc_next;
                        out_invalid <= inv_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2b_ctrl.sv
// Directed self-checking bench for bcd2b_ctrl with DIGITS=4, OUT_W=14.
module tb_bcd2b_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_bin;
    logic        out_invalid;
    logic        busy;

    int unsigned n_total  = 0;
    int unsigned n_passed = 0;

    bcd2b_ctrl #(.DIGITS(4), .OUT_W(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bcd      (in_bcd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bin     (out_bin),
        .out_invalid (out_invalid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_passed++;
        else begin
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
            $error("check %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Ticks until out_valid is seen; returns the number of edges taken, or 0 on timeout.
    task automatic wait_valid(output int unsigned edges);
        edges = 0;
        for (int unsigned i = 1; i <= 20; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic convert(input string tag, input logic [15:0] bcd,
                           input logic [13:0] exp_bin, input logic exp_inv);
        int unsigned edges;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bcd    = bcd;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_bcd   = 16'hFFFF;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_in_ready_conv"}, 32'(in_ready), 32'd0);
        wait_valid(edges);
        check({tag, "_latency"}, 32'(edges), 32'd4);
        check({tag, "_out_bin"}, 32'(out_bin), 32'(exp_bin));
        check({tag, "_out_invalid"}, 32'(out_invalid), 32'(exp_inv));
        tick();
        check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
        check({tag, "_bin_held"}, 32'(out_bin), 32'(exp_bin));
    endtask

    initial begin
        int unsigned edges;

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_bcd    = 16'h1234;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_bin", 32'(out_bin), 32'd0);
        check("rst_out_invalid", 32'(out_invalid), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        convert("h1234", 16'h1234, 14'd1234, 1'b0);
        convert("h9999", 16'h9999, 14'd9999, 1'b0);
        convert("h0000", 16'h0000, 14'd0, 1'b0);
        convert("h12A4", 16'h12A4, 14'd0, 1'b1);
        convert("h0005", 16'h0005, 14'd5, 1'b0);

        // Backpressure: hold result for 3 cycles while a new request waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bcd    = 16'h0321;
        tick();
        in_valid = 1'b0;
        wait_valid(edges);
        check("bp_latency", 32'(edges), 32'd4);
        in_valid = 1'b1;
        in_bcd   = 16'h0042;
        for (int unsigned i = 0; i < 3; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_bin", 32'(out_bin), 32'd321);
            check("bp_out_invalid", 32'(out_invalid), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check("bp_still_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_released", 32'(out_valid), 32'd0);
        check("bp_in_ready_idle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_new_busy", 32'(busy), 32'd1);
        wait_valid(edges);
        check("bp_new_latency", 32'(edges), 32'd4);
        check("bp_new_out_bin", 32'(out_bin), 32'd42);
        tick();

        // Reset asserted during the second CONV cycle discards the conversion.
        in_valid = 1'b1;
        in_bcd   = 16'h8888;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy_low", 32'(busy), 32'd0);
        check("mid_rst_out_bin", 32'(out_bin), 32'd0);
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            check("mid_rst_no_result", 32'(out_valid), 32'd0);
        end
        convert("h0007", 16'h0007, 14'd7, 1'b0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
